gate_fault_checker: RTL and testbench
=====================================

// Module: gate_fault_checker
// PURPOSE
//   Self-timed exhaustive checker for a small combinational gate (e.g. a 2-input AND).
//   Sits around the gate under test: drives every input vector on stim, samples dut_out,
//   and compares it against a built-in golden function.
//   Reports pass/fail, the mismatch count, the first failing vector, and stuck-at-0/1 flags.
// PARAMETERS
//   N_IN     2  number of gate inputs; 2**N_IN vectors are applied, in order 0..2**N_IN-1
//   SETTLE   2  cycles each vector is held before sampling; legal range >=1
//   GOLD_OP  0  golden function over all stim bits: 0=AND 1=OR 2=XOR 3=NAND
// PORTS
//   clk         in   1       rising-edge clock
//   rst         in   1       synchronous, active-high reset
//   start       in   1       begin a sweep; sampled only in IDLE
//   stim        out  N_IN    gate inputs (bit0=a, bit1=b, ...)
//   dut_out     in   1       gate output under test
//   busy        out  1       high from the cycle after start is accepted until DONE inclusive
//   done        out  1       one-cycle pulse; results are valid from this cycle onward
//   pass        out  1       1 when err_count==0; held until the next accepted start
//   err_count   out  N_IN+1  number of mismatching vectors (max 2**N_IN, no saturation)
//   first_fail  out  N_IN    vector of the first mismatch; 0 if there is no mismatch
//   stuck0      out  1       dut_out sampled 0 on every vector and err_count>0
//   stuck1      out  1       dut_out sampled 1 on every vector and err_count>0
// BEHAVIOUR
//   Reset values
//     - All outputs 0; FSM in IDLE; internal vec, settle counter, seen_one and seen_zero = 0.
//   FSM states: IDLE -> SETTLE -> CHECK -> (SETTLE | DONE) -> IDLE
//   IDLE
//     - On start=1: vec=0, stim=0, cnt=0.
//     - Clear err_count, first_fail, pass, stuck0, stuck1, seen_one, seen_zero.
//     - Go to SETTLE.
//   SETTLE
//     - cnt increments each cycle; stim is held.
//     - When cnt==SETTLE-1, go to CHECK.
//   CHECK (1 cycle)
//     - Compare dut_out with golden(vec) using case inequality, so X/Z counts as a mismatch.
//     - On mismatch: err_count+=1; on the first mismatch also latch first_fail=vec.
//     - Set seen_one if dut_out===1; set seen_zero if dut_out===0.
//     - If vec==2**N_IN-1, go to DONE. Otherwise vec+=1, stim=vec+1, cnt=0, go to SETTLE.
//   DONE (1 cycle)
//     - done=1, pass=(err_count==0), stuck0=!seen_one&&err>0, stuck1=!seen_zero&&err>0.
//     - stim returns to 0. Go to IDLE.
//   Latency
//     - start is sampled at edge E0.
//     - done is high during cycle 2**N_IN*(SETTLE+1)+1 after E0 (13 for the defaults).
//   Boundary rules
//     - start while busy (including the DONE cycle): ignored; it is not queued.
//     - start in the first IDLE cycle after DONE: accepted; results clear at the next edge.
//     - Results persist in IDLE until the next accepted start or rst.
//     - rst at any time, including mid-sweep: all outputs and state go to reset values
//       at that edge; no done pulse is emitted.
//     - err_count==2**N_IN (every vector wrong) is representable; it must not wrap.
//     - stim changes only on CHECK->SETTLE, IDLE->SETTLE and DONE->IDLE transitions.
// TESTING (defaults N_IN=2, SETTLE=2, GOLD_OP=0, DUT = the behavioural gate variant named)
//   1. Correct AND; pulse start -> done at cycle 13, pass=1, err=0, first_fail=00,
//      stuck0=0, stuck1=0.
//   2. Stuck-at-0 gate (out=0) -> pass=0, err=1, first_fail=11, stuck0=1, stuck1=0.
//   3. Stuck-at-1 gate (out=1) -> pass=0, err=3, first_fail=00, stuck0=0, stuck1=1.
//   4. XOR in place of AND -> err=3, first_fail=01, stuck0=0, stuck1=0;
//      stim sequence 00,01,10,11, each held 3 cycles.
//   5. Correct AND; rst at cycle 5 after start -> next cycle busy=0, stim=00, err=0,
//      and no done pulse. A start held high for 3 cycles while busy -> exactly one
//      sweep and one done pulse.
//   6. Back-to-back: start during DONE is ignored; start one cycle later -> results
//      clear, then a second done 13 cycles later with the same values as scenario 1.

Source files
------------

// File: rtl/gate_fault_checker.sv
// ============================================================================
//  Module   : gate_fault_checker
//  Brief    : Self-timed exhaustive sweep of a small combinational gate against
//             a golden function; reports pass, mismatch count, first failing
//             vector and stuck-at flags.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module gate_fault_checker #(
    parameter int N_IN    = 2,
    parameter int SETTLE  = 2,
    parameter int GOLD_OP = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail,
    output logic            stuck0,
    output logic            stuck1
);

    localparam int              c_cnt_w    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SETTLE - 1);
    localparam logic [N_IN-1:0] c_vec_last = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [N_IN-1:0]     r_vec;
    logic [N_IN-1:0]     r_stim;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [N_IN:0]       r_err_count;
    logic [N_IN-1:0]     r_first_fail;
    logic                r_pass;
    logic                r_stuck0;
    logic                r_stuck1;
    logic                r_seen_one;
    logic                r_seen_zero;

    logic                w_gold;
    logic                w_mismatch;
    logic [N_IN:0]       w_err_next;
    logic                w_seen_one_next;
    logic                w_seen_zero_next;

    always_comb begin
        w_gold = &r_vec;
        case (GOLD_OP)
            1:       w_gold = |r_vec;
            2:       w_gold = ^r_vec;
            3:       w_gold = ~&r_vec;
            default: w_gold = &r_vec;
        endcase
    end

    // Case inequality so an X/Z gate output is always scored as a mismatch.
    assign w_mismatch       = (dut_out !== w_gold);
    assign w_err_next       = r_err_count + {{N_IN{1'b0}}, w_mismatch};
    assign w_seen_one_next  = r_seen_one  | (dut_out === 1'b1);
    assign w_seen_zero_next = r_seen_zero | (dut_out === 1'b0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_state_next = (r_vec == c_vec_last) ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec        <= '0;
            r_stim       <= '0;
            r_cnt        <= '0;
            r_err_count  <= '0;
            r_first_fail <= '0;
            r_pass       <= 1'b0;
            r_stuck0     <= 1'b0;
            r_stuck1     <= 1'b0;
            r_seen_one   <= 1'b0;
            r_seen_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vec        <= '0;
                        r_stim       <= '0;
                        r_cnt        <= '0;
                        r_err_count  <= '0;
                        r_first_fail <= '0;
                        r_pass       <= 1'b0;
                        r_stuck0     <= 1'b0;
                        r_stuck1     <= 1'b0;
                        r_seen_one   <= 1'b0;
                        r_seen_zero  <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt != c_cnt_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    r_err_count <= w_err_next;
                    r_seen_one  <= w_seen_one_next;
                    r_seen_zero <= w_seen_zero_next;
                    if (w_mismatch && (r_err_count == '0)) begin
                        r_first_fail <= r_vec;
                    end
                    // Verdicts use the post-update tallies so they are valid in DONE.
                    if (r_vec == c_vec_last) begin
                        r_pass   <= (w_err_next == '0);
                        r_stuck0 <= !w_seen_one_next  && (w_err_next != '0);
                        r_stuck1 <= !w_seen_zero_next && (w_err_next != '0);
                    end else begin
                        r_vec  <= r_vec + 1'b1;
                        r_stim <= r_vec + 1'b1;
                        r_cnt  <= '0;
                    end
                end
                S_DONE: begin
                    r_stim <= '0;
                end
                default: begin
                    r_stim <= '0;
                end
            endcase
        end
    end

    assign stim       = r_stim;
    assign err_count  = r_err_count;
    assign first_fail = r_first_fail;
    assign pass       = r_pass;
    assign stuck0     = r_stuck0;
    assign stuck1     = r_stuck1;

endmodule

`default_nettype wire

// File: tb/tb_gate_fault_checker.sv
// ============================================================================
//  Module   : tb_gate_fault_checker
//  Brief    : Self-checking bench for gate_fault_checker using a truth-table
//             gate model and a behavioural sweep reference.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gate_fault_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] stim;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [1:0] first_fail;
    logic       stuck0;
    logic       stuck1;

    // Gate under test: output for vector v is tt[v].
    logic [3:0] tt;
    assign dut_out = tt[stim];

    int total = 0;
    int bad   = 0;

    int         s_lat;
    int         s_npulse;
    logic       s_pass, s_s0, s_s1;
    logic [2:0] s_err;
    logic [1:0] s_ff;
    logic [1:0] stim_hist [1:12];

    logic [3:0] k_tt   [4] = '{4'b1000, 4'b0000, 4'b1111, 4'b0110};
    int         k_err  [4] = '{0, 1, 3, 3};
    int         k_ff   [4] = '{0, 3, 0, 1};
    logic       k_pass [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic       k_s0   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       k_s1   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    gate_fault_checker #(.N_IN(2), .SETTLE(2), .GOLD_OP(0)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stim       (stim),
        .dut_out    (dut_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail),
        .stuck0     (stuck0),
        .stuck1     (stuck1)
    );

    // Expected sweep results for an AND golden function over a truth table.
    task automatic ref_model(input logic [3:0] t, output int e_err, output int e_ff,
                             output logic e_pass, output logic e_s0, output logic e_s1);
        int ones = 0;
        int zeros = 0;
        e_err = 0;
        e_ff  = 0;
        for (int v = 0; v < 4; v++) begin
            logic g;
            g = (v == 3);
            if (t[v] !== g) begin
                if (e_err == 0) e_ff = v;
                e_err++;
            end
            if (t[v] === 1'b1) ones++;
            if (t[v] === 1'b0) zeros++;
        end
        e_pass = (e_err == 0);
        e_s0   = (ones == 0) && (e_err > 0);
        e_s1   = (zeros == 0) && (e_err > 0);
    endtask

    // One start pulse, then observe 20 cycles; cycle k is the k-th cycle after the accepting edge.
    task automatic sweep(input logic [3:0] t);
        tt = t;
        @(negedge clk);
        start    = 1'b1;
        s_lat    = -1;
        s_npulse = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k <= 12) stim_hist[k] = stim;
            if (done === 1'b1) begin
                s_npulse++;
                if (s_lat < 0) begin
                    s_lat  = k;
                    s_pass = pass;
                    s_err  = err_count;
                    s_ff   = first_fail;
                    s_s0   = stuck0;
                    s_s1   = stuck1;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        tt    = 4'b1000;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, pass, stuck0, stuck1} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000", {busy, done, pass, stuck0, stuck1});
        end
        total++;
        if ({err_count, first_fail, stim} !== 7'b0) begin
            bad++;
            $display("FAIL reset_values: got err=%0d ff=%0d stim=%0d want 0", err_count, first_fail, stim);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_known_gates();
        for (int i = 0; i < 4; i++) begin
            logic stim_ok;
            sweep(k_tt[i]);
            total++;
            if (s_lat !== 13 || s_npulse !== 1) begin
                bad++;
                $display("FAIL known%0d_latency: got lat=%0d pulses=%0d want 13/1", i, s_lat, s_npulse);
            end
            total++;
            if (s_err !== 3'(k_err[i]) || s_ff !== 2'(k_ff[i])) begin
                bad++;
                $display("FAIL known%0d_err: got err=%0d ff=%0d want %0d/%0d", i, s_err, s_ff, k_err[i], k_ff[i]);
            end
            total++;
            if ({s_pass, s_s0, s_s1} !== {k_pass[i], k_s0[i], k_s1[i]}) begin
                bad++;
                $display("FAIL known%0d_flags: got %b want %b", i, {s_pass, s_s0, s_s1}, {k_pass[i], k_s0[i], k_s1[i]});
            end
            stim_ok = 1'b1;
            for (int k = 1; k <= 12; k++) begin
                if (stim_hist[k] !== 2'((k - 1) / 3)) stim_ok = 1'b0;
            end
            total++;
            if (!stim_ok) begin
                bad++;
                $display("FAIL known%0d_stim_seq: got %0d %0d %0d %0d (cycles 1,4,7,10) want 0 1 2 3",
                         i, stim_hist[1], stim_hist[4], stim_hist[7], stim_hist[10]);
            end
            total++;
            if (busy !== 1'b0 || stim !== 2'b0 || err_count !== 3'(k_err[i]) || pass !== k_pass[i]) begin
                bad++;
                $display("FAIL known%0d_persist: got busy=%b stim=%0d err=%0d pass=%b want 0/0/%0d/%b",
                         i, busy, stim, err_count, pass, k_err[i], k_pass[i]);
            end
        end
    endtask

    task automatic test_rst_mid();
        int pulses;
        int lat;
        tt = 4'b1111;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        total++;
        if (busy !== 1'b1 || err_count !== 3'd1) begin
            bad++;
            $display("FAIL rst_mid_pre: got busy=%b err=%0d want 1/1", busy, err_count);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || stim !== 2'b0 || err_count !== 3'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_post: got busy=%b stim=%0d err=%0d done=%b want 0/0/0/0",
                     busy, stim, err_count, done);
        end
        rst    = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL rst_mid_no_done: got %0d pulses want 0", pulses);
        end
        // Start held for 3 cycles: only the first is accepted.
        tt = 4'b1000;
        @(negedge clk);
        start  = 1'b1;
        pulses = 0;
        lat    = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 3) start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
        total++;
        if (pulses != 1 || lat != 13 || pass !== 1'b1) begin
            bad++;
            $display("FAIL held_start: got pulses=%0d lat=%0d pass=%b want 1/13/1", pulses, lat, pass);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int lat;
        tt = 4'b0000;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_done: got done=%b want 1", done);
        end
        start = 1'b1;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || err_count !== 3'd1 || stuck0 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ignored: got done=%b busy=%b err=%0d s0=%b want 0/0/1/1",
                     done, busy, err_count, stuck0);
        end
        tt = 4'b1000;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || err_count !== 3'b0 || first_fail !== 2'b0 ||
            stuck0 !== 1'b0 || pass !== 1'b0) begin
            bad++;
            $display("FAIL b2b_cleared: got busy=%b err=%0d ff=%0d s0=%b pass=%b want 1/0/0/0/0",
                     busy, err_count, first_fail, stuck0, pass);
        end
        pulses = 0;
        lat    = -1;
        for (int k = 16; k <= 35; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat    = k;
                    s_pass = pass;
                    s_err  = err_count;
                    s_ff   = first_fail;
                    s_s0   = stuck0;
                    s_s1   = stuck1;
                end
            end
        end
        total++;
        if (pulses != 1 || lat != 27) begin
            bad++;
            $display("FAIL b2b_second_done: got pulses=%0d cycle=%0d want 1/27", pulses, lat);
        end
        total++;
        if ({s_pass, s_err, s_ff, s_s0, s_s1} !== {1'b1, 3'd0, 2'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL b2b_results: got pass=%b err=%0d ff=%0d s0=%b s1=%b want 1/0/0/0/0",
                     s_pass, s_err, s_ff, s_s0, s_s1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] t;
            int   e_err, e_ff;
            logic e_pass, e_s0, e_s1;
            for (int b = 0; b < 4; b++) begin
                case ($urandom_range(0, 4))
                    0, 1:    t[b] = 1'b0;
                    2, 3:    t[b] = 1'b1;
                    default: t[b] = 1'bx;
                endcase
            end
            ref_model(t, e_err, e_ff, e_pass, e_s0, e_s1);
            sweep(t);
            total++;
            if (s_lat !== 13 || s_npulse !== 1) begin
                bad++;
                $display("FAIL rand%0d_latency: tt=%b got lat=%0d pulses=%0d want 13/1", i, t, s_lat, s_npulse);
            end
            total++;
            if (s_err !== 3'(e_err) || s_ff !== 2'(e_ff) || {s_pass, s_s0, s_s1} !== {e_pass, e_s0, e_s1}) begin
                bad++;
                $display("FAIL rand%0d_results: tt=%b got err=%0d ff=%0d p/s0/s1=%b want %0d/%0d/%b",
                         i, t, s_err, s_ff, {s_pass, s_s0, s_s1}, e_err, e_ff, {e_pass, e_s0, e_s1});
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_gates();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
